// File: rtl/ahb_sync_pkg.sv
// Shared types and register map for the AHB register-transfer handshake initiator.
package ahb_sync_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        REQ_HI = 2'd2,
        REQ_LO = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_DADR  = 2'd0;
    localparam logic [1:0] ADDR_CADR  = 2'd1;
    localparam logic [1:0] ADDR_FLAGS = 2'd2;
    localparam logic [1:0] ADDR_CTRL  = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

endpackage

// File: rtl/ack_sync.sv
// Flop chain bringing the responder's raw ack into the HCLK domain.
module ack_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/ahb_sync_init.sv
// Initiator for the four-phase req/ack register transfer; stages, queues one start, launches.
//   state  | meaning
//   IDLE   | no transfer, req low
//   LOAD   | launch registers take staging (or queued) values
//   REQ_HI | req high, waiting for synchronized ack high
//   REQ_LO | req low, waiting for synchronized ack low
module ahb_sync_init
    import ahb_sync_pkg::*;
#(
    parameter int AW          = 6,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int TO_W        = 8
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_addr,
    input  logic [7:0]    cfg_wdata,
    input  logic          ack,
    output logic          req,
    output logic [AW-1:0] DADR,
    output logic [AW-1:0] CADR,
    output logic          DLEN,
    output logic          DBIT,
    output logic          busy,
    output logic          pending,
    output logic          done,
    output logic          timeout_err,
    output logic          overrun
);

    state_t          state, state_nxt;
    logic            ack_s;
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;
    logic            wr_start, wr_clear;
    logic [AW-1:0]   stg_dadr, stg_cadr, q_dadr, q_cadr;
    logic            stg_dlen, stg_dbit, q_dlen, q_dbit;
    logic            unused_wdata;

    ack_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk (HCLK),
        .rst (HRESET),
        .d   (ack),
        .q   (ack_s)
    );

    assign wr_start     = cfg_we && (cfg_addr == ADDR_CTRL) && cfg_wdata[CTRL_START];
    assign wr_clear     = cfg_we && (cfg_addr == ADDR_CTRL) && cfg_wdata[CTRL_CLEAR];
    assign to_hit       = ((state == REQ_HI) || (state == REQ_LO)) && (to_cnt == TO_W'(TIMEOUT));
    assign busy         = (state != IDLE);
    assign unused_wdata = ^cfg_wdata;

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        unique case (state)
            IDLE:    if (wr_start) state_nxt = LOAD;
            LOAD:    state_nxt = REQ_HI;
            REQ_HI:  begin
                if (to_hit)     state_nxt = IDLE;
                else if (ack_s) state_nxt = REQ_LO;
            end
            REQ_LO:  begin
                if (to_hit) begin
                    state_nxt = IDLE;
                end else if (!ack_s) begin
                    done      = 1'b1;
                    // a start landing on the completion edge is queued, so it also chains
                    state_nxt = (pending || wr_start) ? LOAD : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= IDLE;
            req         <= 1'b0;
            to_cnt      <= '0;
            DADR        <= '0;
            CADR        <= '0;
            DLEN        <= 1'b0;
            DBIT        <= 1'b0;
            pending     <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
            stg_dadr    <= '0;
            stg_cadr    <= '0;
            stg_dlen    <= 1'b0;
            stg_dbit    <= 1'b0;
            q_dadr      <= '0;
            q_cadr      <= '0;
            q_dlen      <= 1'b0;
            q_dbit      <= 1'b0;
        end else begin
            state <= state_nxt;
            // registered so the launched data leads req by one full cycle
            req   <= (state == REQ_HI) && (state_nxt == REQ_HI);

            if (state_nxt != state)                      to_cnt <= '0;
            else if ((state == REQ_HI) || (state == REQ_LO)) to_cnt <= to_cnt + 1'b1;

            if (cfg_we && (cfg_addr == ADDR_DADR)) stg_dadr <= cfg_wdata[AW-1:0];
            if (cfg_we && (cfg_addr == ADDR_CADR)) stg_cadr <= cfg_wdata[AW-1:0];
            if (cfg_we && (cfg_addr == ADDR_FLAGS)) begin
                stg_dlen <= cfg_wdata[0];
                stg_dbit <= cfg_wdata[1];
            end

            if (state == LOAD) begin
                DADR <= pending ? q_dadr : stg_dadr;
                CADR <= pending ? q_cadr : stg_cadr;
                DLEN <= pending ? q_dlen : stg_dlen;
                DBIT <= pending ? q_dbit : stg_dbit;
            end

            if (wr_clear) begin
                timeout_err <= 1'b0;
                overrun     <= 1'b0;
            end

            if (to_hit) begin
                timeout_err <= 1'b1;
                pending     <= 1'b0;
            end else if ((state == LOAD) && pending) begin
                pending <= 1'b0;
                if (wr_start) overrun <= 1'b1;
            end else if (wr_start && (state != IDLE)) begin
                if (pending) begin
                    overrun <= 1'b1;
                end else begin
                    pending <= 1'b1;
                    q_dadr  <= stg_dadr;
                    q_cadr  <= stg_cadr;
                    q_dlen  <= stg_dlen;
                    q_dbit  <= stg_dbit;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_sync_init.sv
// Bench for ahb_sync_init: timestamp-based transfer model, directed scenarios, then random traffic.
module tb_ahb_sync_init;
    import ahb_sync_pkg::*;

    localparam int AW   = 6;
    localparam int SYNC = 2;
    localparam int TMO  = 40;
    localparam int TW   = 6;
    localparam int LW   = 2*AW + 2;

    logic          HCLK = 1'b0;
    logic          HRESET, cfg_we, ack;
    logic [1:0]    cfg_addr;
    logic [7:0]    cfg_wdata;
    logic          req, DLEN, DBIT, busy, pending, done, timeout_err, overrun;
    logic [AW-1:0] DADR, CADR;

    ahb_sync_init #(.AW(AW), .SYNC_STAGES(SYNC), .TIMEOUT(TMO), .TO_W(TW)) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .ack         (ack),
        .req         (req),
        .DADR        (DADR),
        .CADR        (CADR),
        .DLEN        (DLEN),
        .DBIT        (DBIT),
        .busy        (busy),
        .pending     (pending),
        .done        (done),
        .timeout_err (timeout_err),
        .overrun     (overrun)
    );

    always #5 HCLK = ~HCLK;

    int n_chk  = 0;
    int n_fail = 0;
    int n      = 0;

    // reference model: staging, queue, flags, and event times of the current handshake
    logic [AW-1:0] m_sdadr, m_scadr;
    logic          m_sdlen, m_sdbit;
    logic [LW-1:0] m_q, m_nxt, m_out;
    bit            m_active, m_pend, m_ovr, m_tmo, hs_on;
    int            t_rise, ta, td, t_pclr;
    int            ack_mode = 0;   // 0 random delays, 1 fixed delays, 2 never ack

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at step %0d: got %0h expected %0h", tag, n, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] stg_word();
        return {m_sdadr, m_scadr, m_sdlen, m_sdbit};
    endfunction

    task automatic model_reset();
        m_sdadr = '0; m_scadr = '0; m_sdlen = 1'b0; m_sdbit = 1'b0;
        m_q = '0; m_nxt = '0; m_out = '0;
        m_active = 0; m_pend = 0; m_ovr = 0; m_tmo = 0; hs_on = 0;
        t_rise = 0; ta = -1; td = -1; t_pclr = -1;
        ack = 1'b0;
    endtask

    // One cycle: check outputs at the negedge, then drive inputs for the next posedge.
    task automatic step(input bit we, input logic [1:0] a, input logic [7:0] d, input bit rst);
        @(negedge HCLK);
        n++;
        if (hs_on && n == t_rise - 1) m_out = m_nxt;
        check_eq("req",         req,   hs_on && n >= t_rise && (ta < 0 || n < ta + SYNC + 1));
        check_eq("done",        done,  hs_on && td >= 0 && n == td + SYNC);
        check_eq("busy",        busy,        m_active);
        check_eq("pending",     pending,     m_pend);
        check_eq("overrun",     overrun,     m_ovr);
        check_eq("timeout_err", timeout_err, m_tmo);
        check_eq("launch",      {DADR, CADR, DLEN, DBIT}, m_out);

        if (hs_on && n == t_rise && ack_mode != 2)
            ta = n + ((ack_mode == 1) ? 3 : int'($urandom_range(3, 0)));
        if (hs_on && ta >= 0 && n == ta) begin
            ack = 1'b1;
            td  = ta + SYNC + 1 + ((ack_mode == 1) ? 1 : int'($urandom_range(3, 0)));
        end
        if (hs_on && td >= 0 && n == td) ack = 1'b0;

        HRESET    = rst;
        cfg_we    = we;
        cfg_addr  = a;
        cfg_wdata = d;
        if (rst) begin
            model_reset();
        end else if (we) begin
            case (a)
                ADDR_DADR:  m_sdadr = d[AW-1:0];
                ADDR_CADR:  m_scadr = d[AW-1:0];
                ADDR_FLAGS: {m_sdbit, m_sdlen} = d[1:0];
                default: begin
                    if (d[1]) begin m_ovr = 0; m_tmo = 0; end
                    if (d[0]) begin
                        if (!m_active) begin
                            m_active = 1; hs_on = 1; m_nxt = stg_word();
                            t_rise = n + 3; ta = -1; td = -1;
                        end else if (!m_pend) begin
                            m_pend = 1; m_q = stg_word();
                        end else begin
                            m_ovr = 1;
                        end
                    end
                end
            endcase
        end

        if (!rst && n == t_pclr) m_pend = 0;

        if (hs_on && td >= 0 && n == td + SYNC) begin
            if (m_pend) begin
                m_nxt = m_q; t_rise = n + 3; ta = -1; td = -1; t_pclr = n + 1;
            end else begin
                hs_on = 0; m_active = 0;
            end
        end else if (hs_on && ta < 0 && n == t_rise + TMO - 1) begin
            hs_on = 0; m_active = 0; m_pend = 0; m_tmo = 1;
        end
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 8'd0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        step(1'b1, a, d, 1'b0);
    endtask

    task automatic drain(input int limit);
        int k = 0;
        while (m_active && k < limit) begin
            idle();
            k++;
        end
        idle();
        check_eq("drain_busy", busy, 0);
    endtask

    initial begin
        HRESET = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'd0;
        model_reset();
        repeat (2) @(negedge HCLK);
        step(1'b0, 2'd0, 8'd0, 1'b1);
        idle();

        // basic transfer with fixed responder timing, staging write while REQ_HI
        ack_mode = 1;
        wr(ADDR_DADR, 8'b0000_1101);
        wr(ADDR_CADR, 8'b0001_1111);
        wr(ADDR_FLAGS, 8'b0000_0011);
        wr(ADDR_CTRL, 8'h01);
        for (int k = 0; k < 20 && n < t_rise + 1; k++) idle();
        wr(ADDR_DADR, 8'b0011_1111);
        drain(60);

        // queued start with different staging, chained without an IDLE gap
        ack_mode = 0;
        wr(ADDR_CTRL, 8'h01);
        wr(ADDR_DADR, 8'b0011_1111);
        wr(ADDR_CADR, 8'b0001_1000);
        wr(ADDR_FLAGS, 8'h00);
        wr(ADDR_CTRL, 8'h01);
        drain(100);

        // three starts while busy: one launches, one queues, one overruns; then clear
        wr(ADDR_CTRL, 8'h01);
        wr(ADDR_CTRL, 8'h01);
        wr(ADDR_CTRL, 8'h01);
        idle();
        wr(ADDR_CTRL, 8'h02);
        drain(100);

        // responder never answers
        ack_mode = 2;
        wr(ADDR_CTRL, 8'h01);
        drain(TMO + 20);
        wr(ADDR_CTRL, 8'h02);
        idle();

        // reset while in REQ_LO, then a normal transfer
        ack_mode = 1;
        wr(ADDR_CTRL, 8'h01);
        for (int k = 0; k < 40 && !(ta >= 0 && n >= ta + SYNC + 1); k++) idle();
        step(1'b0, 2'd0, 8'd0, 1'b1);
        idle();
        wr(ADDR_DADR, 8'h2A);
        wr(ADDR_CTRL, 8'h01);
        drain(60);

        // random traffic with random responder delays
        ack_mode = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(399, 0) == 0)
                step(1'b0, 2'd0, 8'd0, 1'b1);
            else if ($urandom_range(9, 0) < 5)
                wr(2'($urandom_range(3, 0)), 8'($urandom));
            else
                idle();
        end
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
